instr_mem_pipe: RTL

Parametrised, synchronous-read instruction memory for the pipelined 16-bit core, replacing the combinational lookup table.
- IF stage issues fetch requests over a valid/ready handshake and receives registered instruction words one cycle later.
- A load port writes the program at run time.
- After reset the array is swept to NOP (16'h0000), so uninitialised words never reach decode.

---
 rtl/instr_mem_pipe.sv | 151 +++++++++++++++
 1 files changed

// File: rtl/instr_mem_pipe.sv
// Synchronous-read instruction memory with valid/ready fetch port, run-time load port and post-reset NOP sweep.
// Define IMEM_PARITY_EN to store a per-word even-parity bit with error injection on load and a rsp_perr flag.
module instr_mem_pipe #(
    parameter int DATA_W = 16,
    parameter int ADDR_W = 16,
    parameter int DEPTH  = 256
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              req_valid,
    input  logic [ADDR_W-1:0] req_addr,
    output logic              req_ready,
    output logic              rsp_valid,
    output logic [DATA_W-1:0] rsp_data,
    output logic              rsp_err,
    input  logic              rsp_ready,
    input  logic              flush,
    input  logic              ld_en,
    input  logic [ADDR_W-1:0] ld_addr,
    input  logic [DATA_W-1:0] ld_data,
`ifdef IMEM_PARITY_EN
    input  logic              ld_perr_inj,
    output logic              rsp_perr,
`endif
    output logic              busy
);

    localparam int                IDX_W    = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [ADDR_W:0]   DEPTH_X  = (ADDR_W + 1)'(DEPTH);
    localparam logic [IDX_W-1:0]  LAST_IDX = IDX_W'(DEPTH - 1);

    typedef enum logic {
        ST_CLEAR = 1'b0,
        ST_RUN   = 1'b1
    } state_t;

    state_t            state_q;
    logic [IDX_W-1:0]  cnt_q;
    logic [DATA_W-1:0] mem_q [DEPTH];
    logic              rsp_valid_q;
    logic [DATA_W-1:0] rsp_data_q;
    logic              rsp_err_q;

    logic              req_in_range_s;
    logic              ld_in_range_s;
    logic              accept_s;
    logic              wr_en_s;
    logic [IDX_W-1:0]  wr_idx_s;
    logic [DATA_W-1:0] wr_data_s;

    // Full-width unsigned compare so out-of-range addresses never alias onto low words.
    assign req_in_range_s = ({1'b0, req_addr} < DEPTH_X);
    assign ld_in_range_s  = ({1'b0, ld_addr} < DEPTH_X);

    assign req_ready = (state_q == ST_RUN) && !ld_en && !flush && (!rsp_valid_q || rsp_ready);
    assign accept_s  = req_valid && req_ready;
    assign busy      = (state_q == ST_CLEAR);
    assign rsp_valid = rsp_valid_q;
    assign rsp_data  = rsp_data_q;
    assign rsp_err   = rsp_err_q;

    // Write-port mux: the sweep owns the array in CLEAR, the load port in RUN.
    always_comb begin
        wr_en_s   = 1'b0;
        wr_idx_s  = ld_addr[IDX_W-1:0];
        wr_data_s = ld_data;
        if (!rst) begin
            wr_en_s = 1'b0;
        end else if (state_q == ST_CLEAR) begin
            wr_en_s   = 1'b1;
            wr_idx_s  = cnt_q;
            wr_data_s = {DATA_W{1'b0}};
        end else begin
            wr_en_s = ld_en && ld_in_range_s;
        end
    end

    // Sweep sequencer: CLEAR walks every word once, then RUN until the next reset.
    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q <= ST_CLEAR;
            cnt_q   <= {IDX_W{1'b0}};
        end else begin
            case (state_q)
                ST_CLEAR: begin
                    cnt_q <= cnt_q + IDX_W'(1);
                    if (cnt_q == LAST_IDX) begin
                        state_q <= ST_RUN;
                    end
                end
                ST_RUN:  state_q <= ST_RUN;
                default: state_q <= ST_CLEAR;
            endcase
        end
    end

    // Storage array; contents are defined by the sweep rather than by reset.
    always_ff @(posedge clk) begin
        if (wr_en_s) begin
            mem_q[wr_idx_s] <= wr_data_s;
        end
    end

    // Response register: flush wins, then a new fetch, then consumption; otherwise hold.
    always_ff @(posedge clk) begin
        if (!rst) begin
            rsp_valid_q <= 1'b0;
            rsp_data_q  <= {DATA_W{1'b0}};
            rsp_err_q   <= 1'b0;
        end else if (flush) begin
            rsp_valid_q <= 1'b0;
        end else if (accept_s) begin
            rsp_valid_q <= 1'b1;
            rsp_data_q  <= req_in_range_s ? mem_q[req_addr[IDX_W-1:0]] : {DATA_W{1'b0}};
            rsp_err_q   <= !req_in_range_s;
        end else if (rsp_ready) begin
            rsp_valid_q <= 1'b0;
        end
    end

`ifdef IMEM_PARITY_EN
    logic par_q [DEPTH];
    logic rsp_perr_q;
    logic wr_par_s;

    function automatic logic even_par_f(input logic [DATA_W-1:0] d);
        return ^d;
    endfunction

    assign wr_par_s = (state_q == ST_CLEAR) ? 1'b0 : (even_par_f(ld_data) ^ ld_perr_inj);
    assign rsp_perr = rsp_perr_q;

    // Parity bit array, written alongside the data word.
    always_ff @(posedge clk) begin
        if (wr_en_s) begin
            par_q[wr_idx_s] <= wr_par_s;
        end
    end

    // Parity check result follows the data register's load/hold behaviour.
    always_ff @(posedge clk) begin
        if (!rst) begin
            rsp_perr_q <= 1'b0;
        end else if (!flush && accept_s) begin
            rsp_perr_q <= req_in_range_s &&
                          (even_par_f(mem_q[req_addr[IDX_W-1:0]]) != par_q[req_addr[IDX_W-1:0]]);
        end
    end
`endif

endmodule
